// File: rtl/grf_arb_pkg.sv
//----------------------------------------------------------------------------
// Module   : grf_arb_pkg
// Brief    : Shared constants and queue entry type for the GRF write arbiter.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package grf_arb_pkg;
   localparam int REG_AW = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] wa;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wq_entry_t;
endpackage

`default_nettype wire

// File: rtl/grf_write_arbiter_if.sv
//----------------------------------------------------------------------------
// Module   : grf_write_arbiter_if
// Brief    : Pipeline, secondary, GRF and scoreboard signals of the arbiter.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface grf_write_arbiter_if #(
   parameter int DEPTH = 4
);
   import grf_arb_pkg::*;

   logic                         p_we;
   logic [REG_AW-1:0]            p_wa;
   logic [DATA_W-1:0]            p_wd;
   logic [DATA_W-1:0]            p_pc;
   logic                         s_valid;
   logic                         s_ready;
   logic [REG_AW-1:0]            s_wa;
   logic [DATA_W-1:0]            s_wd;
   logic [DATA_W-1:0]            s_pc;
   logic                         grf_we;
   logic [REG_AW-1:0]            grf_wa;
   logic [DATA_W-1:0]            grf_wd;
   logic [DATA_W-1:0]            grf_pc;
   logic [REG_AW-1:0]            chk_ra1;
   logic [REG_AW-1:0]            chk_ra2;
   logic                         busy1;
   logic                         busy2;
   logic [$clog2(DEPTH+1)-1:0]   q_count;

   modport master (
      output p_we, p_wa, p_wd, p_pc,
      output s_valid, s_wa, s_wd, s_pc,
      output chk_ra1, chk_ra2,
      input  s_ready, grf_we, grf_wa, grf_wd, grf_pc,
      input  busy1, busy2, q_count
   );

   modport slave (
      input  p_we, p_wa, p_wd, p_pc,
      input  s_valid, s_wa, s_wd, s_pc,
      input  chk_ra1, chk_ra2,
      output s_ready, grf_we, grf_wa, grf_wd, grf_pc,
      output busy1, busy2, q_count
   );
endinterface

`default_nettype wire

// File: rtl/grf_wq_fifo.sv
//----------------------------------------------------------------------------
// Module   : grf_wq_fifo
// Brief    : Circular write queue with a per-entry wa/valid view.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module grf_wq_fifo
   import grf_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire                          clk,
   input  wire                          rst,
   input  wire                          push,
   input  wq_entry_t                    din,
   input  wire                          pop,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output wq_entry_t                    head,
   output logic [DEPTH*REG_AW-1:0]      wa_flat,
   output logic [DEPTH-1:0]             vld_flat
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   wq_entry_t        r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] r_vld;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign count     = r_count;
   assign head      = r_mem[r_head];
   assign vld_flat  = r_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_do_pop) begin
            r_head        <= r_head + PW'(1);
            r_vld[r_head] <= 1'b0;
         end
         if (w_do_push) begin
            r_tail        <= r_tail + PW'(1);
            r_vld[r_tail] <= 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; r_vld qualifies every entry.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_tail] <= din;
      end
   end

   always_comb begin
      wa_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wa_flat[i*REG_AW +: REG_AW] = r_mem[i].wa;
      end
   end
endmodule

`default_nettype wire

// File: rtl/grf_write_arbiter.sv
//----------------------------------------------------------------------------
// Module   : grf_write_arbiter
// Brief    : Shares the GRF write port between pipeline writeback and a
//            queued secondary producer; optional GRF_ARB_BYPASS_EN.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module grf_write_arbiter
   import grf_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input wire                 clk,
   input wire                 reset,
   grf_write_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH+1);

   logic                    w_p_eff;
   logic                    w_s_ok;
   logic                    w_bypass;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [CW-1:0]           w_count;
   wq_entry_t               w_head;
   wq_entry_t               w_s_entry;
   logic [DEPTH*REG_AW-1:0] w_wa_flat;
   logic [DEPTH-1:0]        w_vld;

   assign w_p_eff   = bus.p_we && (bus.p_wa != REG_ZERO);
   assign w_s_ok    = bus.s_valid && (bus.s_wa != REG_ZERO);
   assign w_s_entry = '{wa: bus.s_wa, wd: bus.s_wd, pc: bus.s_pc};

`ifdef GRF_ARB_BYPASS_EN
   assign w_bypass = w_empty && !w_p_eff && w_s_ok && !reset;
`else
   assign w_bypass = 1'b0;
`endif

   assign bus.s_ready = !w_full && !reset;
   assign w_push      = w_s_ok && bus.s_ready && !w_bypass;
   assign w_pop       = !w_p_eff && !w_empty;
   assign bus.q_count = w_count;

   grf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .push     (w_push),
      .din      (w_s_entry),
      .pop      (w_pop),
      .full     (w_full),
      .empty    (w_empty),
      .count    (w_count),
      .head     (w_head),
      .wa_flat  (w_wa_flat),
      .vld_flat (w_vld)
   );

   always_comb begin
      bus.grf_we = 1'b0;
      bus.grf_wa = w_head.wa;
      bus.grf_wd = w_head.wd;
      bus.grf_pc = w_head.pc;
      if (reset) begin
         bus.grf_we = 1'b0;
      end else if (w_p_eff) begin
         bus.grf_we = 1'b1;
         bus.grf_wa = bus.p_wa;
         bus.grf_wd = bus.p_wd;
         bus.grf_pc = bus.p_pc;
      end else if (!w_empty) begin
         bus.grf_we = 1'b1;
      end else if (w_bypass) begin
         bus.grf_we = 1'b1;
         bus.grf_wa = bus.s_wa;
         bus.grf_wd = bus.s_wd;
         bus.grf_pc = bus.s_pc;
      end
   end

   // $0 is never busy, regardless of stale queue contents.
   always_comb begin
      bus.busy1 = 1'b0;
      bus.busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_vld[i] && (w_wa_flat[i*REG_AW +: REG_AW] == bus.chk_ra1)) bus.busy1 = 1'b1;
         if (w_vld[i] && (w_wa_flat[i*REG_AW +: REG_AW] == bus.chk_ra2)) bus.busy2 = 1'b1;
      end
      if (bus.chk_ra1 == REG_ZERO) bus.busy1 = 1'b0;
      if (bus.chk_ra2 == REG_ZERO) bus.busy2 = 1'b0;
   end
endmodule

`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
//----------------------------------------------------------------------------
// Module   : tb_grf_write_arbiter
// Brief    : Scoreboard bench for grf_write_arbiter; honours GRF_ARB_BYPASS_EN.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_grf_write_arbiter;
   import grf_arb_pkg::*;

   localparam int DEPTH = 4;
`ifdef GRF_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct { bit we; bit ready; int qc; bit b1; bit b2; } cyc_t;
   typedef struct { logic [4:0] wa; logic [31:0] wd; logic [31:0] pc; } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   grf_write_arbiter_if #(.DEPTH(DEPTH)) bus ();
   grf_write_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   cyc_t cyc_q[$];
   wr_t  wr_q[$];
   wr_t  model_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   bit   last_ready;
   cyc_t mc;
   wr_t  mw;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_busy(input logic [4:0] ra);
      bit b = 1'b0;
      foreach (model_q[i]) if (model_q[i].wa == ra) b = 1'b1;
      return b && (ra != 5'd0);
   endfunction

   // Reference: pipeline beats queue, queue beats bypass; ready judged before pop.
   task automatic drive(input bit pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input bit sv, input logic [4:0] swa, input logic [31:0] swd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
      cyc_t c;
      bit peff, byp, rdy;
      logic [31:0] ppc, spc;
      ppc = $urandom;
      spc = $urandom;
      bus.p_we = pwe; bus.p_wa = pwa; bus.p_wd = pwd; bus.p_pc = ppc;
      bus.s_valid = sv; bus.s_wa = swa; bus.s_wd = swd; bus.s_pc = spc;
      bus.chk_ra1 = ra1; bus.chk_ra2 = ra2;
      peff = pwe && (pwa != 5'd0);
      rdy  = model_q.size() < DEPTH;
      byp  = BYP && (model_q.size() == 0) && !peff && sv && (swa != 5'd0);
      c.ready = rdy;
      c.qc    = model_q.size();
      c.b1    = model_busy(ra1);
      c.b2    = model_busy(ra2);
      c.we    = 1'b1;
      if (peff) wr_q.push_back('{pwa, pwd, ppc});
      else if (model_q.size() > 0) wr_q.push_back(model_q.pop_front());
      else if (byp) wr_q.push_back('{swa, swd, spc});
      else c.we = 1'b0;
      if (sv && rdy && (swa != 5'd0) && !byp) model_q.push_back('{swa, swd, spc});
      cyc_q.push_back(c);
      last_ready = rdy;
   endtask

   task automatic step(input bit pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                       input bit sv, input logic [4:0] swa, input logic [31:0] swd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
      @(posedge clk);
      #1;
      drive(pwe, pwa, pwd, sv, swa, swd, ra1, ra2);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (cyc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cyc_q: got no record expected one at %0t", $time);
         end else begin
            mc = cyc_q.pop_front();
            chk("s_ready", {31'd0, bus.s_ready}, {31'd0, mc.ready});
            chk("q_count", {29'd0, bus.q_count}, mc.qc);
            chk("busy1",   {31'd0, bus.busy1},   {31'd0, mc.b1});
            chk("busy2",   {31'd0, bus.busy2},   {31'd0, mc.b2});
            chk("grf_we",  {31'd0, bus.grf_we},  {31'd0, mc.we});
         end
         if (bus.grf_we) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL grf_write: got write to %0d expected none at %0t", bus.grf_wa, $time);
            end else begin
               mw = wr_q.pop_front();
               chk("grf_wa", {27'd0, bus.grf_wa}, {27'd0, mw.wa});
               chk("grf_wd", bus.grf_wd, mw.wd);
               chk("grf_pc", bus.grf_pc, mw.pc);
            end
         end
      end
   end

   initial begin
      bit pwe, sv, hold;
      logic [4:0] pwa, swa;
      logic [31:0] swd;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      cyc_q.delete(); wr_q.delete();
      #2;
      chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("rst_grf_we",  {31'd0, bus.grf_we},  32'd0);
      chk("rst_q_count", {29'd0, bus.q_count}, 32'd0);
      chk("rst_busy1",   {31'd0, bus.busy1},   32'd0);
      #6 reset = 1'b0;

      // Pipeline only
      step(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
      mon_en = 1'b1;
      #1;
      chk("pipe_we", {31'd0, bus.grf_we}, 32'd1);
      chk("pipe_wa", {27'd0, bus.grf_wa}, 32'd8);
      chk("pipe_wd", bus.grf_wd, 32'h1234);

      // Contention: $9 lands one cycle after the pipeline write
      step(1'b1, 5'd2, 32'h5, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      #1;
      chk("cont_wa", {27'd0, bus.grf_wa}, 32'd9);
      chk("cont_wd", bus.grf_wd, 32'hAA);
      chk("cont_busy", {31'd0, bus.busy1}, 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      #1;
      chk("cont_busy_clr", {31'd0, bus.busy1}, 32'd0);

      // Fill under a pipeline stream, then drain in order
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 5'd3, 32'h30 + i, 1'b1, 5'(10 + i), 32'hA0 + i, 5'd10, 5'd13);
      step(1'b1, 5'd3, 32'h3F, 1'b0, 5'd0, 32'd0, 5'd10, 5'd13);
      #1;
      chk("fill_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("fill_count", {29'd0, bus.q_count}, 32'd4);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd13);
         #1;
         chk("drain_wa", {27'd0, bus.grf_wa}, 32'(10 + i));
         if (i == 1) chk("drain_ready", {31'd0, bus.s_ready}, 32'd1);
      end

      // $0 handling
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
      #1;
      chk("z_ready", {31'd0, bus.s_ready}, 32'd1);
      chk("z_we",    {31'd0, bus.grf_we},  32'd0);
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 5'd6, 5'd0);
      step(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
      #1;
      chk("z_drain_wa", {27'd0, bus.grf_wa}, 32'd6);

      // Bypass path
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h77, 5'd5, 5'd0);
      #1;
`ifdef GRF_ARB_BYPASS_EN
      chk("byp_we", {31'd0, bus.grf_we}, 32'd1);
      chk("byp_wa", {27'd0, bus.grf_wa}, 32'd5);
`else
      chk("nobyp_we", {31'd0, bus.grf_we}, 32'd0);
`endif

      // Randomised traffic with alternating heavy/light pipeline load
      hold = 1'b0; sv = 1'b0; swa = '0; swd = '0;
      for (int n = 0; n < 800; n++) begin
         pwe = $urandom_range(0, 99) < (((n / 50) % 2 == 0) ? 85 : 20);
         pwa = 5'($urandom_range(0, 7));
         if (!hold) begin
            sv  = $urandom_range(0, 99) < 60;
            swa = 5'($urandom_range(0, 7));
            swd = $urandom;
         end
         step(pwe, pwa, $urandom, sv, swa, swd,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         hold = sv && !last_ready;
      end

      // Async reset with three entries queued
      for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'd3, 32'd0, 1'b1, 5'(1 + i), 32'hC0 + i, 5'd1, 5'd2);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      bus.p_we = 1'b0; bus.s_valid = 1'b0;
      #1;
      chk("pre_rst_count", {29'd0, bus.q_count}, 32'd3);
      #1 reset = 1'b1;
      #1;
      chk("arst_count", {29'd0, bus.q_count}, 32'd0);
      chk("arst_busy1", {31'd0, bus.busy1},   32'd0);
      chk("arst_busy2", {31'd0, bus.busy2},   32'd0);
      chk("arst_we",    {31'd0, bus.grf_we},  32'd0);
      chk("arst_ready", {31'd0, bus.s_ready}, 32'd0);
      cyc_q.delete(); wr_q.delete(); model_q.delete();
      @(posedge clk);
      #3 reset = 1'b0;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd3);

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("wr_q_empty", wr_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
